// File: rtl/change_dispenser_pkg.sv
// Shared vending machine definitions: money widths, coin values, timer reload
// and the dispenser state encoding.
package vending_machine_def;
  localparam int kNumCoins  = 3;
  localparam int kTotalBits = 31;
  localparam int kWaitTime  = 10;
  localparam int COIN0      = 100;
  localparam int COIN1      = 500;
  localparam int COIN2      = 1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    RETURN = 2'd2
  } state_t;
endpackage

// File: rtl/change_dispenser_coin_select.sv
// Combinational priority encoder: picks the largest coin that fits in the
// remaining balance and flags a balance too small for any coin.
module coin_select
  import vending_machine_def::*;
#(
  parameter int kNumCoins  = vending_machine_def::kNumCoins,
  parameter int kTotalBits = vending_machine_def::kTotalBits,
  parameter int COIN0      = vending_machine_def::COIN0,
  parameter int COIN1      = vending_machine_def::COIN1,
  parameter int COIN2      = vending_machine_def::COIN2
) (
  input  logic [kTotalBits-1:0] i_rem,
  output logic [kNumCoins-1:0]  o_coin,
  output logic [kTotalBits-1:0] o_value,
  output logic                  o_residue
);
  localparam logic [kTotalBits-1:0] C0 = kTotalBits'(COIN0);
  localparam logic [kTotalBits-1:0] C1 = kTotalBits'(COIN1);
  localparam logic [kTotalBits-1:0] C2 = kTotalBits'(COIN2);

  always_comb begin
    o_coin    = '0;
    o_value   = '0;
    o_residue = 1'b0;
    if (i_rem >= C2) begin
      o_coin[2] = 1'b1;
      o_value   = C2;
    end else if (i_rem >= C1) begin
      o_coin[1] = 1'b1;
      o_value   = C1;
    end else if (i_rem >= C0) begin
      o_coin[0] = 1'b1;
      o_value   = C0;
    end else begin
      o_residue = (i_rem != '0);
    end
  end
endmodule

// File: rtl/change_dispenser.sv
// Inactivity timer plus change return: on timeout or request, pays out the
// balance one coin per handshake, largest denomination first.
module change_dispenser
  import vending_machine_def::*;
#(
  parameter int kNumCoins  = vending_machine_def::kNumCoins,
  parameter int kTotalBits = vending_machine_def::kTotalBits,
  parameter int kWaitTime  = vending_machine_def::kWaitTime,
  parameter int COIN0      = vending_machine_def::COIN0,
  parameter int COIN1      = vending_machine_def::COIN1,
  parameter int COIN2      = vending_machine_def::COIN2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [kNumCoins-1:0]  i_input_coin,
  input  logic                  i_output_event,
  input  logic                  i_trigger_return,
  input  logic [kTotalBits-1:0] current_total,
  input  logic                  i_return_ready,
  output logic [kNumCoins-1:0]  o_return_coin,
  output logic                  o_return_valid,
  output logic                  o_change_residue,
  output logic [31:0]           wait_time,
  output logic                  o_busy
);
  state_t                r_state, w_state_nxt;
  logic [31:0]           r_wait, w_wait_nxt;
  logic [kTotalBits-1:0] r_rem, w_rem_nxt;
  logic [kNumCoins-1:0]  w_sel;
  logic [kTotalBits-1:0] w_sel_val, w_in_val, w_sub, w_sat;
  logic [kTotalBits:0]   w_sum;
  logic                  w_residue, w_busy, w_valid, w_fire, w_coin_in;

  coin_select #(
    .kNumCoins(kNumCoins), .kTotalBits(kTotalBits),
    .COIN0(COIN0), .COIN1(COIN1), .COIN2(COIN2)
  ) u_sel (
    .i_rem(r_rem), .o_coin(w_sel), .o_value(w_sel_val), .o_residue(w_residue)
  );

  assign w_busy    = (r_state == RETURN);
  assign w_valid   = w_busy && (w_sel != '0);
  assign w_fire    = w_valid && i_return_ready;
  assign w_coin_in = |i_input_coin;

  always_comb begin
    w_in_val = '0;
    if (i_input_coin[2])      w_in_val = kTotalBits'(COIN2);
    else if (i_input_coin[1]) w_in_val = kTotalBits'(COIN1);
    else if (i_input_coin[0]) w_in_val = kTotalBits'(COIN0);
  end

  // Deduct first (cannot underflow), then add the insert with saturation.
  assign w_sub = r_rem - (w_fire ? w_sel_val : '0);
  assign w_sum = {1'b0, w_sub} + {1'b0, w_in_val};
  assign w_sat = w_sum[kTotalBits] ? '1 : w_sum[kTotalBits-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_rem_nxt   = r_rem;
    case (r_state)
      IDLE: begin
        if (w_coin_in) begin
          w_state_nxt = WAIT;
          w_wait_nxt  = 32'(kWaitTime);
        end else if (i_trigger_return && current_total != '0) begin
          w_state_nxt = RETURN;
          w_rem_nxt   = current_total;
        end
      end
      WAIT: begin
        if (w_coin_in || i_output_event) begin
          w_wait_nxt = 32'(kWaitTime);
        end else if (i_trigger_return || r_wait <= 32'd1) begin
          w_state_nxt = RETURN;
          w_rem_nxt   = current_total;
          w_wait_nxt  = '0;
        end else begin
          w_wait_nxt = r_wait - 32'd1;
        end
      end
      RETURN: begin
        w_wait_nxt = '0;
        if (r_rem == '0 || w_residue) begin
          w_state_nxt = IDLE;
          w_rem_nxt   = '0;
        end else begin
          w_rem_nxt = w_sat;
          if (w_sat == '0) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_wait  <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  assign o_return_valid   = w_valid;
  assign o_return_coin    = w_valid ? w_sel : '0;
  assign o_change_residue = w_busy && w_residue;
  assign wait_time        = r_wait;
  assign o_busy           = w_busy;
endmodule
